// File: rtl/serial_subtractor_if.sv
// Start/done handshake and operand/result bus for the bit-serial subtractor.
// The master side issues operations and the slave side computes them.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
) ();
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;
  logic             busy;
  logic             done;

  modport master (
    output start, a, b, bin,
    input  diff, bout, ovf, busy, done
  );

  modport slave (
    input  start, a, b, bin,
    output diff, bout, ovf, busy, done
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial A - B - bin using one full-subtractor cell and a borrow flop.
// Results are published only on completion and are held until the next one.
//   state  | meaning
//   S_IDLE | waiting for start
//   S_RUN  | one bit per clock, LSB first, WIDTH clocks
//   S_DONE | one-cycle done pulse; start here is accepted back-to-back
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  serial_subtractor_if.slave bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;

  logic             d_bit;
  logic             br_nxt;
  logic [WIDTH-1:0] res_shift;

  assign d_bit     = a_sh_q[0] ^ b_sh_q[0] ^ br_q;
  assign br_nxt    = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & br_q);
  assign res_shift = {d_bit, res_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          br_d    = bus.bin;
          res_d   = '0;
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        res_d  = res_shift;
        br_d   = br_nxt;
        if (cnt_q == CNT_LAST) begin
          // Last step: the operand LSBs now hold the original MSBs.
          diff_d  = res_shift;
          bout_d  = br_nxt;
          ovf_d   = (a_sh_q[0] ^ b_sh_q[0]) & (d_bit ^ a_sh_q[0]);
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
  assign bus.ovf  = ovf_q;
  assign bus.busy = (state_q == S_RUN);
  assign bus.done = (state_q == S_DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomized checks of serial_subtractor at WIDTH=8 and WIDTH=16.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(8))  if8 ();
  serial_subtractor_if #(.WIDTH(16)) if16 ();

  serial_subtractor #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(if8.slave));
  serial_subtractor #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(if16.slave));

  // Issues one 8-bit op, returns results and done latency (-1 on timeout).
  task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                         output logic [7:0] d, output logic bo, output logic ov,
                         output int lat, output int busy_cyc, output logic diff_moved);
    logic [7:0] diff_before;
    diff_before = if8.diff;
    diff_moved  = 1'b0;
    if8.a = a; if8.b = b; if8.bin = bin; if8.start = 1'b1;
    @(posedge clk); #1;
    if8.start = 1'b0;
    busy_cyc = if8.busy ? 1 : 0;
    lat = -1;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #1;
      if (if8.done) begin lat = i; break; end
      if (if8.busy) busy_cyc++;
      if (if8.diff !== diff_before) diff_moved = 1'b1;
    end
    d = if8.diff; bo = if8.bout; ov = if8.ovf;
  endtask

  task automatic run_op16(input logic [15:0] a, input logic [15:0] b, input logic bin,
                          output logic [15:0] d, output logic bo, output logic ov,
                          output int lat);
    if16.a = a; if16.b = b; if16.bin = bin; if16.start = 1'b1;
    @(posedge clk); #1;
    if16.start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (if16.done) begin lat = i; break; end
    end
    d = if16.diff; bo = if16.bout; ov = if16.ovf;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (if8.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", if8.busy); end
    checks++; if (if8.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", if8.done); end
    checks++; if (if8.diff !== 8'h00) begin errors++; $display("FAIL reset_diff: got %h expected 00", if8.diff); end
    checks++; if ({if8.bout, if8.ovf} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b expected 00", {if8.bout, if8.ovf}); end
    checks++; if ({if16.busy, if16.done} !== 2'b00) begin errors++; $display("FAIL reset_w16: got %b expected 00", {if16.busy, if16.done}); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [7:0] d; logic bo, ov, moved; int lat, bc;
    run_op8(8'h5A, 8'h1F, 1'b0, d, bo, ov, lat, bc, moved);
    checks++; if (lat !== 8) begin errors++; $display("FAIL basic_latency: got %0d expected 8", lat); end
    checks++; if (bc !== 8) begin errors++; $display("FAIL basic_busy_cycles: got %0d expected 8", bc); end
    checks++; if (moved !== 1'b0) begin errors++; $display("FAIL basic_diff_held: got %b expected 0", moved); end
    checks++; if ({bo, ov, d} !== {2'b00, 8'h3B}) begin errors++; $display("FAIL basic_result: got %b%b_%h expected 00_3b", bo, ov, d); end
    @(posedge clk); #1;
    checks++; if ({if8.done, if8.busy} !== 2'b00) begin errors++; $display("FAIL basic_done_pulse: got %b expected 00", {if8.done, if8.busy}); end
    checks++; if (if8.diff !== 8'h3B) begin errors++; $display("FAIL basic_diff_hold_idle: got %h expected 3b", if8.diff); end
  endtask

  task automatic test_vectors();
    logic [7:0] va[4] = '{8'h10, 8'h80, 8'h00, 8'h7F};
    logic [7:0] vb[4] = '{8'h20, 8'h01, 8'h00, 8'hFF};
    logic       vi[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [7:0] ed[4] = '{8'hF0, 8'h7F, 8'hFF, 8'h80};
    logic       eb[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic       eo[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0] d; logic bo, ov, moved; int lat, bc;
    for (int k = 0; k < 4; k++) begin
      run_op8(va[k], vb[k], vi[k], d, bo, ov, lat, bc, moved);
      checks++;
      if (lat !== 8 || {bo, ov, d} !== {eb[k], eo[k], ed[k]}) begin
        errors++;
        $display("FAIL vector_%0d: got lat=%0d %b%b_%h expected lat=8 %b%b_%h", k, lat, bo, ov, d, eb[k], eo[k], ed[k]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] va[3] = '{8'h5A, 8'h80, 8'h7F};
    logic [7:0] vb[3] = '{8'h1F, 8'h01, 8'hFF};
    logic [7:0] ed[3] = '{8'h3B, 8'h7F, 8'h80};
    logic       eb[3] = '{1'b0, 1'b0, 1'b1};
    logic       eo[3] = '{1'b0, 1'b1, 1'b1};
    int cyc;
    if8.a = va[0]; if8.b = vb[0]; if8.bin = 1'b0; if8.start = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      cyc = -1;
      for (int i = 1; i <= 30; i++) begin
        @(posedge clk); #1;
        if (i == 3) begin if8.a = ~if8.a; if8.b = 8'hA5; if8.bin = 1'b1; end
        if (if8.done) begin cyc = i; break; end
      end
      checks++;
      if (cyc !== 8 || {if8.bout, if8.ovf, if8.diff} !== {eb[k], eo[k], ed[k]}) begin
        errors++;
        $display("FAIL b2b_op_%0d: got lat=%0d %b%b_%h expected lat=8 %b%b_%h", k, cyc, if8.bout, if8.ovf, if8.diff, eb[k], eo[k], ed[k]);
      end
      if (k < 2) begin
        if8.a = va[k+1]; if8.b = vb[k+1]; if8.bin = 1'b0;
      end else begin
        if8.start = 1'b0;
      end
      @(posedge clk); #1;
      checks++;
      if ({if8.done, if8.busy} !== {1'b0, (k < 2) ? 1'b1 : 1'b0}) begin
        errors++;
        $display("FAIL b2b_pulse_%0d: got done,busy=%b expected %b", k, {if8.done, if8.busy}, {1'b0, (k < 2) ? 1'b1 : 1'b0});
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d; logic bo, ov, moved; int lat, bc;
    if8.a = 8'h10; if8.b = 8'h20; if8.bin = 1'b0; if8.start = 1'b1;
    @(posedge clk); #1;
    if8.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({if8.busy, if8.done, if8.bout, if8.ovf, if8.diff} !== 12'h000) begin
      errors++;
      $display("FAIL midrst_state: got busy=%b done=%b bout=%b ovf=%b diff=%h expected all zero", if8.busy, if8.done, if8.bout, if8.ovf, if8.diff);
    end
    @(posedge clk); #1;
    run_op8(8'h03, 8'h05, 1'b0, d, bo, ov, lat, bc, moved);
    checks++;
    if (lat !== 8 || {bo, ov, d} !== {2'b10, 8'hFE}) begin
      errors++;
      $display("FAIL midrst_after: got lat=%0d %b%b_%h expected lat=8 10_fe", lat, bo, ov, d);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random8();
    logic [7:0] a, b, d; logic bin, bo, ov, moved; int lat, bc;
    logic [8:0] full; int sr; logic eovf;
    for (int n = 0; n < 1000; n++) begin
      a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
      run_op8(a, b, bin, d, bo, ov, lat, bc, moved);
      full = {1'b0, a} - {1'b0, b} - {8'd0, bin};
      sr = int'($signed(a)) - int'($signed(b)) - int'(bin);
      eovf = (sr > 127) || (sr < -128);
      checks++;
      if (lat !== 8 || {bo, d} !== full || ov !== eovf) begin
        errors++;
        $display("FAIL rand8: a=%h b=%h bin=%b got lat=%0d %b_%h ovf=%b expected %h ovf=%b", a, b, bin, lat, bo, d, ov, full, eovf);
        if (lat < 0) break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random16();
    logic [15:0] a, b, d; logic bin, bo, ov; int lat;
    logic [16:0] full; int sr; logic eovf;
    for (int n = 0; n < 1000; n++) begin
      a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom);
      run_op16(a, b, bin, d, bo, ov, lat);
      full = {1'b0, a} - {1'b0, b} - {16'd0, bin};
      sr = int'($signed(a)) - int'($signed(b)) - int'(bin);
      eovf = (sr > 32767) || (sr < -32768);
      checks++;
      if (lat !== 16 || {bo, d} !== full || ov !== eovf) begin
        errors++;
        $display("FAIL rand16: a=%h b=%h bin=%b got lat=%0d %b_%h ovf=%b expected %h ovf=%b", a, b, bin, lat, bo, d, ov, full, eovf);
        if (lat < 0) break;
      end
    end
  endtask

  initial begin
    if8.start = 1'b0;  if8.a = '0;  if8.b = '0;  if8.bin = 1'b0;
    if16.start = 1'b0; if16.a = '0; if16.b = '0; if16.bin = 1'b0;
    test_reset();
    test_basic();
    test_vectors();
    test_back_to_back();
    test_reset_mid();
    test_random8();
    test_random16();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
